// File: rtl/count_sequence_checker.sv
// Monitors a free-running up-counter: locks onto a +1 sequence, flags steps that break it, counts wraps.
// COUNT_SEQ_HOLD_TOLERANT_EN makes a repeated value (q_in == prev) neutral instead of a bad step.
module count_sequence_checker #(
   parameter int WIDTH      = 3,
   parameter int LOCK_COUNT = 4,
   parameter int ERR_LIMIT  = 2,
   parameter int WRAP_W     = 8,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 clear,
   input  logic                 valid,
   input  logic [WIDTH-1:0]     q_in,
   output logic                 locked,
   output logic                 err_pulse,
   output logic                 wrap_pulse,
   output logic [WRAP_W-1:0]    wrap_count,
   output logic [ERR_CNT_W-1:0] err_count
);

   // state  | meaning
   // IDLE   | waiting for the first sample to capture as reference
   // SYNC   | counting consecutive good steps toward lock
   // LOCKED | sequence tracked; bad steps reported and counted
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam int GW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT);
   localparam int BW = (ERR_LIMIT < 2) ? 1 : $clog2(ERR_LIMIT);
   localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_COUNT - 1);
   localparam logic [BW-1:0] ERR_LAST  = BW'(ERR_LIMIT - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_prev;
   logic [GW-1:0]    r_good_cnt;
   logic [BW-1:0]    r_bad_cnt;

   logic [WIDTH-1:0] w_prev_inc;
   logic             w_good;
   logic             w_wrap;
   logic             w_neutral;

   assign w_prev_inc = r_prev + 1'b1;
   assign w_good     = (q_in == w_prev_inc);
   assign w_wrap     = (r_prev == {WIDTH{1'b1}}) && (q_in == '0);
`ifdef COUNT_SEQ_HOLD_TOLERANT_EN
   assign w_neutral  = (q_in == r_prev);
`else
   assign w_neutral  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (clear) begin
         r_state    <= ST_IDLE;
         r_prev     <= '0;
         r_good_cnt <= '0;
         r_bad_cnt  <= '0;
         locked     <= 1'b0;
         err_pulse  <= 1'b0;
         wrap_pulse <= 1'b0;
         wrap_count <= '0;
         err_count  <= '0;
      end else begin
         err_pulse  <= 1'b0;
         wrap_pulse <= 1'b0;
         if (valid) begin
            case (r_state)
               ST_IDLE: begin
                  r_prev     <= q_in;
                  r_good_cnt <= '0;
                  r_state    <= ST_SYNC;
               end
               ST_SYNC: begin
                  if (!w_neutral) begin
                     r_prev <= q_in;
                     if (w_good) begin
                        if (r_good_cnt == LOCK_LAST) begin
                           r_state    <= ST_LOCKED;
                           r_good_cnt <= '0;
                           r_bad_cnt  <= '0;
                           locked     <= 1'b1;
                        end else begin
                           r_good_cnt <= r_good_cnt + 1'b1;
                        end
                     end else begin
                        r_good_cnt <= '0;
                     end
                  end
               end
               ST_LOCKED: begin
                  if (!w_neutral) begin
                     r_prev <= q_in;
                     if (w_good) begin
                        r_bad_cnt <= '0;
                        if (w_wrap) begin
                           wrap_pulse <= 1'b1;
                           wrap_count <= wrap_count + 1'b1;
                        end
                     end else begin
                        err_pulse <= 1'b1;
                        if (err_count != {ERR_CNT_W{1'b1}})
                           err_count <= err_count + 1'b1;
                        // ERR_LIMIT-th consecutive bad step drops back to SYNC
                        if (r_bad_cnt == ERR_LAST) begin
                           r_state    <= ST_SYNC;
                           r_good_cnt <= '0;
                           r_bad_cnt  <= '0;
                           locked     <= 1'b0;
                        end else begin
                           r_bad_cnt <= r_bad_cnt + 1'b1;
                        end
                     end
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  locked  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed bench for count_sequence_checker with a cycle-level reference model and per-cycle compare.
module tb_count_sequence_checker;

   logic       clk = 1'b0;
   logic       clear;
   logic       valid;
   logic [2:0] q_in;
   logic       locked;
   logic       err_pulse;
   logic       wrap_pulse;
   logic [7:0] wrap_count;
   logic [7:0] err_count;

   always #5 clk = ~clk;

   count_sequence_checker dut (
      .clk        (clk),
      .clear      (clear),
      .valid      (valid),
      .q_in       (q_in),
      .locked     (locked),
      .err_pulse  (err_pulse),
      .wrap_pulse (wrap_pulse),
      .wrap_count (wrap_count),
      .err_count  (err_count)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   // model: phase 0 = waiting for reference, 1 = acquiring, 2 = locked
   int m_phase, m_prev, m_good_run, m_bad_run;
   int m_wrapc, m_errc, m_errp, m_wrapp;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic model_edge(input bit c, input bit v, input int q);
      bit good_step;
      bit neutral;
      if (c) begin
         m_phase = 0; m_prev = 0; m_good_run = 0; m_bad_run = 0;
         m_wrapc = 0; m_errc = 0; m_errp = 0; m_wrapp = 0;
         return;
      end
      m_errp = 0;
      m_wrapp = 0;
      if (!v) return;
      if (m_phase == 0) begin
         m_prev = q; m_good_run = 0; m_phase = 1;
         return;
      end
`ifdef COUNT_SEQ_HOLD_TOLERANT_EN
      neutral = (q == m_prev);
`else
      neutral = 0;
`endif
      if (neutral) return;
      good_step = (q == (m_prev + 1) % 8);
      if (m_phase == 1) begin
         if (good_step) begin
            m_good_run++;
            if (m_good_run == 4) begin m_phase = 2; m_bad_run = 0; end
         end else m_good_run = 0;
      end else begin
         if (good_step) begin
            m_bad_run = 0;
            if (m_prev == 7 && q == 0) begin m_wrapp = 1; m_wrapc = (m_wrapc + 1) % 256; end
         end else begin
            m_errp = 1;
            if (m_errc < 255) m_errc++;
            m_bad_run++;
            if (m_bad_run == 2) begin m_phase = 1; m_good_run = 0; m_bad_run = 0; end
         end
      end
      m_prev = q;
   endtask

   task automatic step(input bit c, input bit v, input int q);
      clear = c;
      valid = v;
      q_in  = q[2:0];
      @(posedge clk);
      model_edge(c, v, q);
      @(negedge clk);
   endtask

   task automatic feed(input int q);
      step(0, 1, q);
   endtask

   task automatic gap();
      step(0, 0, 3);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("locked",     int'(locked),     (m_phase == 2) ? 1 : 0);
         chk("err_pulse",  int'(err_pulse),  m_errp);
         chk("wrap_pulse", int'(wrap_pulse), m_wrapp);
         chk("wrap_count", int'(wrap_count), m_wrapc);
         chk("err_count",  int'(err_count),  m_errc);
         if (err_pulse && wrap_pulse) chk("pulse_excl", 1, 0);
      end
   end

   initial begin
      int p;
      int w0;
      clear = 1; valid = 1; q_in = 3'd5;
      @(negedge clk);

      // 1: reset with valid sample present
      step(1, 1, 5);
      chk_en = 1;
      step(1, 1, 5);
      chk("t1_locked", int'(locked), 0);
      chk("t1_wcnt",   int'(wrap_count), 0);
      chk("t1_ecnt",   int'(err_count), 0);

      // 2: capture + four good steps
      feed(0); feed(1); feed(2); feed(3);
      chk("t2_not_yet", int'(locked), 0);
      feed(4);
      chk("t2_locked", int'(locked), 1);

      // 3: wrap, then wrap again with gaps
      feed(5); feed(6); feed(7);
      chk("t3_no_wrap", int'(wrap_pulse), 0);
      feed(0);
      chk("t3_wrap_p", int'(wrap_pulse), 1);
      chk("t3_wrap_c", int'(wrap_count), 1);
      gap();
      chk("t3_wrap_end", int'(wrap_pulse), 0);
      for (int i = 1; i <= 8; i++) begin
         feed(i % 8);
         gap();
         if (i < 8) gap();
      end
      chk("t3_gap_wrap_c", int'(wrap_count), 2);
      chk("t3_locked", int'(locked), 1);

      // 4: errors and unlock from prev=2
      feed(1); feed(2);
      feed(5);
      chk("t4_err_p", int'(err_pulse), 1);
      chk("t4_err_c", int'(err_count), 1);
      chk("t4_still_lock", int'(locked), 1);
      feed(6);
      chk("t4_good_p", int'(err_pulse), 0);
      feed(0);
      chk("t4_lock2", int'(locked), 1);
      feed(3);
      chk("t4_err_c3", int'(err_count), 3);
      chk("t4_unlock", int'(locked), 0);
      feed(4); feed(5); feed(6);
      chk("t4_sync", int'(locked), 0);
      feed(7);
      chk("t4_relock", int'(locked), 1);

      // 5: clear mid-lock with a valid sample
      step(1, 1, 1);
      chk("t5_locked", int'(locked), 0);
      chk("t5_ecnt",   int'(err_count), 0);
      chk("t5_wcnt",   int'(wrap_count), 0);
      feed(2); feed(3); feed(4); feed(5);
      chk("t5_not_yet", int'(locked), 0);
      feed(6);
      chk("t5_relock", int'(locked), 1);

      // 6: repeated value while locked with prev=3
      feed(7); feed(0); feed(1); feed(2); feed(3);
      feed(3);
`ifdef COUNT_SEQ_HOLD_TOLERANT_EN
      chk("t6_hold_err_p", int'(err_pulse), 0);
      chk("t6_hold_err_c", int'(err_count), 0);
`else
      chk("t6_hold_err_p", int'(err_pulse), 1);
      chk("t6_hold_err_c", int'(err_count), 1);
`endif
      feed(4);
      chk("t6_good_p", int'(err_pulse), 0);
      chk("t6_locked", int'(locked), 1);

      // error counter saturation: alternate bad/good so lock is kept
      p = 4;
      for (int i = 0; i < 260; i++) begin
         feed((p + 3) % 8);
         feed((p + 4) % 8);
         p = (p + 4) % 8;
      end
      chk("sat_err_c", int'(err_count), 255);
      chk("sat_locked", int'(locked), 1);

      // wrap counter rolls over after 256 wraps
      w0 = m_wrapc;
      for (int i = 0; i < 256 * 8; i++) begin
         p = (p + 1) % 8;
         feed(p);
      end
      chk("wrap_mod", int'(wrap_count), w0);

      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
